gshare_pred: RTL and testbench

Parametrised global-history branch predictor for the fetch stage of the RISC-V core, successor to the fixed 4-bit-history/16-entry predictor. Indexes a table of 2-bit saturating counters with PC bits XOR global history (gshare), predicts JAL always taken and conditional branches by counter MSB, and produces the PC-relative target. Resolved outcomes from execute train the table and shift the history; the lookup index travels down the pipeline with the instruction so training hits the same entry that predicted.

---
 rtl/gshare_pred_pkg.sv | 25 ++
 rtl/bp_sat_ctr.sv | 24 ++
 rtl/gshare_pred.sv | 117 +++++++++++
 tb/tb_gshare_pred.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pred_pkg.sv
// gshare_pred_pkg
//   Shared definitions for the gshare branch predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - RISC-V opcode constants (instruction bits [6:2]) used by the lookup
//   Imported by gshare_pred and bp_sat_ctr.
package gshare_pred_pkg;

    // Counter encoding: MSB set means "predict taken".
    typedef enum logic [1:0] {
        SNT = 2'd0,   // strongly not-taken
        WNT = 2'd1,   // weakly not-taken
        WT  = 2'd2,   // weakly taken
        ST  = 2'd3    // strongly taken
    } ctr_e;

    // Major opcodes, instruction bits [6:2].
    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
    localparam logic [4:0] OPC_JALR_5   = 5'b11001;
    localparam logic [4:0] OPC_JAL_5    = 5'b11011;

    // Legal parameter ranges.
    localparam int IDX_BITS_MIN = 2;
    localparam int IDX_BITS_MAX = 10;

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr
//   Combinational next-value function for a 2-bit saturating counter.
//   Ports:
//     ctr       in  2  current counter value
//     taken     in  1  resolved branch outcome
//     ctr_next  out 2  counter after training (saturates at SNT and ST)
module bp_sat_ctr
    import gshare_pred_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken && (ctr != 2'(ST))) begin
            ctr_next = ctr + 2'd1;
        end else if (!taken && (ctr != 2'(SNT))) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_pred.sv
// gshare_pred
//   Global-history (gshare) branch predictor for the fetch stage.
//   A table of 2^IDX_BITS 2-bit saturating counters is indexed by
//   PC[IDX_BITS+1:2] XOR the global history. JAL always predicts taken,
//   conditional branches use the counter MSB, everything else (incl. JALR)
//   predicts not-taken. The lookup is purely combinational; resolved
//   branches from execute train the entry they were predicted from
//   (u_idx = f_idx carried down the pipe) and shift the history.
//
//   Optional feature macro: BP_STATS_EN
//     defined   -> stat_branches / stat_mispredicts counters and ports exist
//     undefined -> no statistics ports; u_mispredict is ignored
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     f_pc, f_imm, f_opc fetch PC, decoded B/J immediate, instr[6:2]
//     f_predict         predicted taken
//     f_target          f_pc + f_imm (mod 2^32)
//     f_idx             table index used for this lookup
//     u_valid, u_idx, u_taken, u_mispredict  resolved-branch training port
//     stat_branches, stat_mispredicts        statistics (BP_STATS_EN only)
module gshare_pred
    import gshare_pred_pkg::*;
#(
    parameter int         IDX_BITS  = 6,
    parameter int         HIST_BITS = 4,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         f_pc,
    input  logic [31:0]         f_imm,
    input  logic [4:0]          f_opc,
    output logic                f_predict,
    output logic [31:0]         f_target,
    output logic [IDX_BITS-1:0] f_idx,
    input  logic                u_valid,
    input  logic [IDX_BITS-1:0] u_idx,
    input  logic                u_taken,
    input  logic                u_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int PHT_N = 1 << IDX_BITS;

    // Elaboration-time parameter range checks.
    if (IDX_BITS < IDX_BITS_MIN || IDX_BITS > IDX_BITS_MAX) begin : g_bad_idx_bits
        $error("gshare_pred: IDX_BITS out of range");
    end
    if (HIST_BITS < 1 || HIST_BITS > IDX_BITS) begin : g_bad_hist_bits
        $error("gshare_pred: HIST_BITS out of range");
    end

    logic [HIST_BITS-1:0] ghr;
    logic [1:0]           pht [PHT_N];
    logic [1:0]           upd_ctr;
    logic [1:0]           upd_ctr_next;

    // ---------------- Lookup (combinational) ----------------
    assign f_idx    = f_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
    assign f_target = f_pc + f_imm;

    always_comb begin
        f_predict = 1'b0;
        if (f_opc == OPC_JAL_5) begin
            f_predict = 1'b1;
        end else if (f_opc == OPC_BRANCH_5) begin
            f_predict = pht[f_idx][1];
        end
    end

    // ---------------- Update (registered) ----------------
    assign upd_ctr = pht[u_idx];

    bp_sat_ctr u_sat_ctr (
        .ctr      (upd_ctr),
        .taken    (u_taken),
        .ctr_next (upd_ctr_next)
    );

    // Truncating {ghr, u_taken} to HIST_BITS keeps the newest bits, which is
    // a left shift for any HIST_BITS >= 1 (HIST_BITS == 1 reduces to u_taken).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (u_valid) begin
            ghr          <= HIST_BITS'({ghr, u_taken});
            pht[u_idx]   <= upd_ctr_next;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (u_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (u_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    // Misprediction flag only feeds the statistics counters.
    logic unused_mispredict;
    assign unused_mispredict = u_mispredict;
`endif

endmodule

// File: tb/tb_gshare_pred.sv
// tb_gshare_pred
//   Directed, table-driven bench for gshare_pred (IDX_BITS=6, HIST_BITS=4,
//   CTR_INIT=WNT) plus hand-written training / history / reset sequences.
module tb_gshare_pred;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic [31:0] f_imm;
    logic [4:0]  f_opc;
    logic        f_predict;
    logic [31:0] f_target;
    logic [5:0]  f_idx;
    logic        u_valid;
    logic [5:0]  u_idx;
    logic        u_taken;
    logic        u_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_pred #(.IDX_BITS(6), .HIST_BITS(4), .CTR_INIT(2'b01)) dut (
        .clk          (clk),
        .rst          (rst),
        .f_pc         (f_pc),
        .f_imm        (f_imm),
        .f_opc        (f_opc),
        .f_predict    (f_predict),
        .f_target     (f_target),
        .f_idx        (f_idx),
        .u_valid      (u_valid),
        .u_idx        (u_idx),
        .u_taken      (u_taken),
        .u_mispredict (u_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  opc;
        logic        pred;
        logic [31:0] tgt;
        logic [5:0]  idx;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [4:0] opc);
        f_pc  = pc;
        f_opc = opc;
        f_imm = 32'h0;
        #1;
    endtask

    // Drive one training update at the negedge, sample the lookup before the
    // edge (pre-update view), then clear after the edge.
    task automatic train(input logic [5:0] idx, input logic taken, input logic mis);
        @(negedge clk);
        u_valid      = 1'b1;
        u_idx        = idx;
        u_taken      = taken;
        u_mispredict = mis;
        @(posedge clk);
        #1;
        u_valid      = 1'b0;
        u_taken      = 1'b0;
        u_mispredict = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0094, 32'h0000_0010, OPC_BRANCH, 1'b0, 32'h0000_00A4, 6'h25};
        vecs[1] = '{32'h0000_0094, 32'h0000_0010, OPC_JAL,    1'b1, 32'h0000_00A4, 6'h25};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0008, OPC_BRANCH, 1'b0, 32'h0000_0004, 6'h3F};
        vecs[3] = '{32'h0000_1000, 32'hFFFF_FFF0, OPC_JALR,   1'b0, 32'h0000_0FF0, 6'h00};
        vecs[4] = '{32'h0000_0014, 32'h0000_0100, OPC_OP,     1'b0, 32'h0000_0114, 6'h05};
        vecs[5] = '{32'h0000_0014, 32'h0000_0004, OPC_JAL,    1'b1, 32'h0000_0018, 6'h05};

        rst = 1'b1;
        f_pc = 32'h0; f_imm = 32'h0; f_opc = OPC_BRANCH;
        u_valid = 1'b0; u_idx = '0; u_taken = 1'b0; u_mispredict = 1'b0;

        // Outputs must reflect reset state while rst is held.
        #3;
        lookup(32'h0000_0094, OPC_BRANCH);
        chk("rst_branch_pred", {31'b0, f_predict}, 32'd0);
        chk("rst_idx", {26'b0, f_idx}, 32'h25);
        lookup(32'h0000_0094, OPC_JAL);
        chk("rst_jal_pred", {31'b0, f_predict}, 32'd1);
`ifdef BP_STATS_EN
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table of combinational lookups from the reset state.
        for (int i = 0; i < 6; i++) begin
            f_pc  = vecs[i].pc;
            f_imm = vecs[i].imm;
            f_opc = vecs[i].opc;
            #1;
            chk($sformatf("vec%0d_pred", i), {31'b0, f_predict}, {31'b0, vecs[i].pred});
            chk($sformatf("vec%0d_tgt", i), f_target, vecs[i].tgt);
            chk($sformatf("vec%0d_idx", i), {26'b0, f_idx}, {26'b0, vecs[i].idx});
        end

        // Training on index 5: same-cycle lookup sees the pre-update value.
        // ghr starts at 0, so PC 0x14 maps to index 5.
        @(negedge clk);
        lookup(32'h0000_0014, OPC_BRANCH);
        u_valid = 1'b1; u_idx = 6'd5; u_taken = 1'b1; u_mispredict = 1'b1;
        #1;
        chk("same_cycle_pred", {31'b0, f_predict}, 32'd0);
        @(posedge clk);
        #1;
        u_valid = 1'b0; u_taken = 1'b0; u_mispredict = 1'b0;
        // ghr=0001 -> PC 0x10 maps to index 5; counter now WT.
        lookup(32'h0000_0010, OPC_BRANCH);
        chk("train1_idx", {26'b0, f_idx}, 32'd5);
        chk("train1_pred", {31'b0, f_predict}, 32'd1);
        train(6'd5, 1'b1, 1'b0);
        // ghr=0011 -> PC 0x18 maps to index 5; counter ST.
        lookup(32'h0000_0018, OPC_BRANCH);
        chk("train2_idx", {26'b0, f_idx}, 32'd5);
        chk("train2_pred", {31'b0, f_predict}, 32'd1);
        train(6'd5, 1'b1, 1'b0);
        // ghr=0111 -> PC 0x08; counter stays ST (saturated).
        lookup(32'h0000_0008, OPC_BRANCH);
        chk("train3_idx", {26'b0, f_idx}, 32'd5);
        chk("train3_pred", {31'b0, f_predict}, 32'd1);
        train(6'd5, 1'b0, 1'b1);
        // ghr=1110 -> PC 0x2C; ST -> WT still predicts taken (proves saturation).
        lookup(32'h0000_002C, OPC_BRANCH);
        chk("dec1_idx", {26'b0, f_idx}, 32'd5);
        chk("dec1_pred", {31'b0, f_predict}, 32'd1);
        train(6'd5, 1'b0, 1'b0);
        // ghr=1100 -> PC 0x24; WT -> WNT predicts not-taken.
        lookup(32'h0000_0024, OPC_BRANCH);
        chk("dec2_idx", {26'b0, f_idx}, 32'd5);
        chk("dec2_pred", {31'b0, f_predict}, 32'd0);
`ifdef BP_STATS_EN
        chk("stat_br5", stat_branches, 32'd5);
        chk("stat_mis2", stat_mispredicts, 32'd2);
`endif
        // An invalid-cycle with junk u_* must not move anything.
        @(negedge clk);
        u_valid = 1'b0; u_idx = 6'd5; u_taken = 1'b1; u_mispredict = 1'b1;
        @(posedge clk);
        #1;
        u_taken = 1'b0; u_mispredict = 1'b0;
        lookup(32'h0000_0024, OPC_BRANCH);
        chk("novalid_idx", {26'b0, f_idx}, 32'd5);
        chk("novalid_pred", {31'b0, f_predict}, 32'd0);

        // History pattern T,T,N,T from a clean state -> ghr=1101.
        do_reset();
        train(6'd3, 1'b1, 1'b0);
        train(6'd3, 1'b1, 1'b0);
        train(6'd3, 1'b0, 1'b0);
        train(6'd3, 1'b1, 1'b0);
        lookup(32'h0000_0000, OPC_BRANCH);
        chk("ghr_idx", {26'b0, f_idx}, 32'h0D);
        // Index 3 counter: 1->2->3->2->3; PC[7:2]=3^13=14 -> PC 0x38.
        lookup(32'h0000_0038, OPC_BRANCH);
        chk("ghr_idx3", {26'b0, f_idx}, 32'd3);
        chk("ghr_pred3", {31'b0, f_predict}, 32'd1);

        // Asynchronous reset between clock edges clears state immediately.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        lookup(32'h0000_0000, OPC_BRANCH);
        chk("arst_idx", {26'b0, f_idx}, 32'd0);
        lookup(32'h0000_000C, OPC_BRANCH);
        chk("arst_idx3", {26'b0, f_idx}, 32'd3);
        chk("arst_pred3", {31'b0, f_predict}, 32'd0);
        lookup(32'h0000_000C, OPC_JAL);
        chk("arst_jal", {31'b0, f_predict}, 32'd1);
`ifdef BP_STATS_EN
        chk("arst_stat_br", stat_branches, 32'd0);
        chk("arst_stat_mis", stat_mispredicts, 32'd0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
